// File: rtl/debug_cmd_pkg.sv
// Shared constants and the default command type for the CPU debug command capture path.
package debug_cmd_pkg;

   localparam int unsigned DEF_IR_W = 2;
   localparam int unsigned DEF_SR_W = 38;

   localparam logic [DEF_IR_W-1:0] IR_OCIMEM    = 2'd0;
   localparam logic [DEF_IR_W-1:0] IR_TRACEMEM  = 2'd1;
   localparam logic [DEF_IR_W-1:0] IR_BREAK     = 2'd2;
   localparam logic [DEF_IR_W-1:0] IR_TRACECTRL = 2'd3;

   typedef struct packed {
      logic [DEF_IR_W-1:0] ir;
      logic [DEF_SR_W-1:0] data;
   } debug_cmd_t;

endpackage

// File: rtl/sopc_2_cpu_cpu_debug_cmd_sysclk_if.sv
// Command handshake between the capture stage (master) and the debug core (slave).
interface sopc_2_cpu_cpu_debug_cmd_sysclk_if
   import debug_cmd_pkg::*;
#(
   parameter int unsigned IR_W = DEF_IR_W,
   parameter int unsigned SR_W = DEF_SR_W
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [IR_W-1:0]      cmd_ir;
   logic [SR_W-1:0]      cmd_data;
   logic [2**IR_W-1:0]   cmd_action;
   logic [2**IR_W-1:0]   cmd_no_action;

   modport master (
      output cmd_valid, cmd_ir, cmd_data, cmd_action, cmd_no_action,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_ir, cmd_data, cmd_action, cmd_no_action,
      output cmd_ready
   );
endinterface

// File: rtl/debug_cmd_fifo.sv
// Show-ahead synchronous FIFO; push while full is accepted only if a pop happens in the same cycle.
module debug_cmd_fifo
   import debug_cmd_pkg::*;
#(
   parameter type         T     = debug_cmd_t,
   parameter int unsigned Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  T                         data_i,
   input  logic                     pop_i,
   output T                         head_o,
   output logic                     valid_o,
   output logic                     full_o,
   output logic [$clog2(Depth):0]   level_o
);
   localparam int unsigned PtrW = $clog2(Depth);
   localparam logic [PtrW:0] FullLvl = (PtrW+1)'(Depth);

   T [Depth-1:0]    mem_q, mem_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]   level_q, level_d;
   logic            do_push, do_pop;

   always_comb begin
      full_o   = (level_q == FullLvl);
      valid_o  = (level_q != '0);
      head_o   = mem_q[rd_ptr_q];
      level_o  = level_q;
      do_pop   = pop_i && valid_o;
      do_push  = push_i && (!full_o || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      level_d = level_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end
endmodule

// File: rtl/sopc_2_cpu_cpu_debug_cmd_sysclk.sv
// System-clock capture of JTAG debug commands into a queue with valid/ready delivery.
// Optional parity checking of sr[SR_W-1] is enabled by defining DEBUG_CMD_PARITY_EN.
module sopc_2_cpu_cpu_debug_cmd_sysclk
   import debug_cmd_pkg::*;
#(
   parameter int unsigned SR_W        = DEF_SR_W,
   parameter int unsigned IR_W        = DEF_IR_W,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned ACT_BIT     = 34
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              vs_udr,
   input  logic                              vs_uir,
   input  logic [IR_W-1:0]                   ir_in,
   input  logic [SR_W-1:0]                   sr,
   sopc_2_cpu_cpu_debug_cmd_sysclk_if.master cmd_if,
   output logic                              ir_strobe,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
   output logic                              overflow,
   output logic                              parity_err,
   input  logic                              err_clr
);
   typedef struct packed {
      logic [IR_W-1:0] ir;
      logic [SR_W-1:0] data;
   } cmd_t;

   localparam int unsigned LastStage = SYNC_STAGES - 1;

   logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
   logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
   logic                   udr_prev_q, udr_prev_d;
   logic                   uir_prev_q, uir_prev_d;
   logic                   cap_pulse_q, cap_pulse_d;
   logic                   ir_strobe_q, ir_strobe_d;
   logic                   overflow_q, overflow_d;
   logic                   parity_err_q, parity_err_d;
   logic                   parity_ok, push_req, pop, fifo_full, head_valid;
   cmd_t                   cap_cmd, head;

`ifdef DEBUG_CMD_PARITY_EN
   assign parity_ok = ^sr;
`else
   assign parity_ok = 1'b1;
`endif

   // ir_in/sr are quasi-static while vs_udr is high, so they are sampled without synchronisation.
   assign cap_cmd  = '{ir: ir_in, data: sr};
   assign push_req = cap_pulse_q & parity_ok;
   assign pop      = head_valid & cmd_if.cmd_ready;

   always_comb begin
      udr_sync_d  = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_sync_d  = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_prev_d  = udr_sync_q[LastStage];
      uir_prev_d  = uir_sync_q[LastStage];
      cap_pulse_d = udr_sync_q[LastStage] & ~udr_prev_q;
      ir_strobe_d = uir_sync_q[LastStage] & ~uir_prev_q;

      // A new error in the same cycle as err_clr wins.
      overflow_d = overflow_q;
      if (err_clr) overflow_d = 1'b0;
      if (push_req && fifo_full && !pop) overflow_d = 1'b1;

`ifdef DEBUG_CMD_PARITY_EN
      parity_err_d = parity_err_q;
      if (err_clr) parity_err_d = 1'b0;
      if (cap_pulse_q && !parity_ok) parity_err_d = 1'b1;
`else
      parity_err_d = 1'b0;
`endif
   end

   // Sync and history flops reset high so a strobe held across reset yields no edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         udr_sync_q   <= '1;
         uir_sync_q   <= '1;
         udr_prev_q   <= 1'b1;
         uir_prev_q   <= 1'b1;
         cap_pulse_q  <= 1'b0;
         ir_strobe_q  <= 1'b0;
         overflow_q   <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         udr_sync_q   <= udr_sync_d;
         uir_sync_q   <= uir_sync_d;
         udr_prev_q   <= udr_prev_d;
         uir_prev_q   <= uir_prev_d;
         cap_pulse_q  <= cap_pulse_d;
         ir_strobe_q  <= ir_strobe_d;
         overflow_q   <= overflow_d;
         parity_err_q <= parity_err_d;
      end
   end

   debug_cmd_fifo #(
      .T     (cmd_t),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .push_i  (push_req),
      .data_i  (cap_cmd),
      .pop_i   (pop),
      .head_o  (head),
      .valid_o (head_valid),
      .full_o  (fifo_full),
      .level_o (fifo_level)
   );

   assign cmd_if.cmd_valid = head_valid;
   assign cmd_if.cmd_ir    = head.ir;
   assign cmd_if.cmd_data  = head.data;
   assign ir_strobe        = ir_strobe_q;
   assign overflow         = overflow_q;
   assign parity_err       = parity_err_q;

   always_comb begin
      cmd_if.cmd_action    = '0;
      cmd_if.cmd_no_action = '0;
      if (head_valid) begin
         if (head.data[ACT_BIT]) cmd_if.cmd_action[head.ir]    = 1'b1;
         else                    cmd_if.cmd_no_action[head.ir] = 1'b1;
      end
   end
endmodule

// File: doc/sopc_2_cpu_cpu_debug_cmd_sysclk.md
Name: sopc_2_cpu_cpu_debug_cmd_sysclk

Overview:
System-clock-side command capture for the CPU debug slave, and the parametrised successor of the fixed 2-bit-IR / 38-bit-SR capture stage.
- Synchronises the JTAG update-DR and update-IR strobes into clk.
- Captures {IR, shift register} on each update-DR and queues it in a small FIFO.
- Presents queued commands to the debug core with a valid/ready handshake, so back-to-back JTAG updates are not lost.
- Flags overflow; decodes action / no-action per IR code.

Parameters:
SR_W, 38, shift-register / command data width (>=3)
IR_W, 2, virtual-JTAG IR width (1..4)
SYNC_STAGES, 2, synchroniser depth for vs_udr/vs_uir (>=2)
FIFO_DEPTH, 4, command queue entries (power of two, >=2)
ACT_BIT, 34, sr bit index that selects take_action (1) vs take_no_action (0)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vs_udr  in  1  update-DR level from TCK domain (asynchronous)
vs_uir  in  1  update-IR level from TCK domain (asynchronous)
ir_in  in  IR_W  current virtual IR; quasi-static while vs_udr high
sr  in  SR_W  TCK shift register; quasi-static while vs_udr high
cmd_valid  out  1  queue head valid
cmd_ready  in  1  consumer accepts head
cmd_ir  out  IR_W  head IR code
cmd_data  out  SR_W  head data (jdo)
cmd_action  out  2**IR_W  one-hot take_action per IR code, qualified by cmd_valid and cmd_data[ACT_BIT]=1
cmd_no_action  out  2**IR_W  one-hot take_no_action, qualified by cmd_valid and cmd_data[ACT_BIT]=0
ir_strobe  out  1  one-cycle pulse per update-IR
fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy
overflow  out  1  sticky: a command was dropped
parity_err  out  1  sticky parity failure (see Optional Feature)
err_clr  in  1  clears overflow and parity_err

Behaviour:
- Clock/reset: one clock (clk); reset synchronous, active-high.
- Reset values: all outputs 0; FIFO empty. Synchroniser flops and edge-history flops for both strobes reset to 1, so a strobe held high across reset produces no capture.
- Edge detect: rising edge of the last synchroniser stage gives capture_pulse (udr) or ir_strobe (uir).
  - Each pulse lasts exactly one clk.
  - Latency from the input transition to the pulse is SYNC_STAGES+1 clks.
- Capture: on capture_pulse, {ir_in, sr} is sampled directly in that cycle (quasi-static; no extra sync) and pushed. The entry is visible at the head the next cycle.
- FIFO: show-ahead. cmd_valid = !empty. Pop when cmd_valid && cmd_ready. Pointers wrap modulo FIFO_DEPTH.
- Full + push, no pop: command dropped, overflow set; queue contents unchanged.
- Full + push + pop, same cycle: push accepted, level unchanged, no overflow.
- Empty + push: cmd_valid rises the next cycle; no bypass.
- Error flags: err_clr clears overflow/parity_err. If err_clr and a new error occur in the same cycle, the set wins.
- Decode: cmd_action[cmd_ir] = cmd_valid & cmd_data[ACT_BIT]; cmd_no_action likewise with the bit inverted. All other bits 0. Combinational from the head.
- Reset asserted mid-operation: queue flushed immediately; a pending edge in the synchroniser is discarded.

Optional Feature:
Macro DEBUG_CMD_PARITY_EN.
- With it: sr[SR_W-1] is odd parity over sr[SR_W-2:0] (odd parity: XOR of all SR_W bits = 1). On mismatch at capture, the command is not pushed, parity_err is set, and overflow is unaffected.
- Without it: every captured command is pushed, sr[SR_W-1] is passed through as data, and parity_err is tied to 0.

Decomposition:
- Package debug_cmd_pkg: IR code constants (IR_OCIMEM=0, IR_TRACEMEM=1, IR_BREAK=2, IR_TRACECTRL=3) and a packed typedef debug_cmd_t {ir, data} sized from the parameters.
- Sub-module debug_cmd_fifo: generic show-ahead synchronous FIFO holding debug_cmd_t.
- Synchroniser and edge detect stay inline.

Test Plan:
- Basic capture: reset, then ir_in=2'b10, sr=38'h04_0000_0055, pulse vs_udr high for 10 clks -> cmd_valid rises 4 clks after the rise (SYNC_STAGES=2: 3-clk pulse latency + 1 to head); cmd_ir=2, cmd_action=4'b0100, cmd_data=38'h04_0000_0055.
- Backpressure/overflow: hold cmd_ready=0, issue 5 udr pulses with sr=1..5 -> fifo_level=4, overflow=1. Then ready=1 drains data 1,2,3,4 in order; err_clr -> overflow=0.
- Simultaneous push/pop at full: queue full, cmd_ready=1 in the capture-pulse cycle -> level stays 4, overflow stays 0, new entry appears last.
- IR strobe and reset: vs_uir high across reset deassertion -> no ir_strobe. Then low then high -> exactly one ir_strobe pulse.
- No-action decode: sr[34]=0, ir_in=0 -> cmd_no_action=4'b0001, cmd_action=0.
- Parity (DEBUG_CMD_PARITY_EN): sr with even total parity -> no push, parity_err=1. Correct parity -> pushed normally.
